// File: rtl/mezcla_pkg.sv
// ----------------------------------------------------------------------------
// Module  : mezcla_pkg
// Brief   : Default plant constants and timer state encoding for the mixer
//           plant emulator.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mezcla_pkg;

   // Default plant constants
   localparam int c_w_def        = 8;
   localparam int c_lvl_max_def  = 200;
   localparam int c_fill1_def    = 4;
   localparam int c_fill2_def    = 2;
   localparam int c_drain_def    = 5;
   localparam int c_drain_b_def  = 3;
   localparam int c_high_th_def  = 160;
   localparam int c_low_th_def   = 0;
   localparam int c_t_cycles_def = 10;

   // Timer state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } temp_state_t;

endpackage : mezcla_pkg

`default_nettype wire

// File: rtl/mezcla_temporizador.sv
// ----------------------------------------------------------------------------
// Module  : mezcla_temporizador
// Brief   : Process timer. A rising edge of T arms a T_CYCLES count; TOK pulses
//           for one cycle when the count expires. Dropping T aborts the run.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mezcla_temporizador
   import mezcla_pkg::*;
#(
   parameter int T_CYCLES = c_t_cycles_def
) (
   input  logic Clk,
   input  logic Reset,
   input  logic T,
   output logic TOK
);

   localparam int                c_cw   = (T_CYCLES > 2) ? $clog2(T_CYCLES) : 1;
   localparam logic [c_cw-1:0]   c_load = c_cw'(T_CYCLES - 1);

   temp_state_t      r_state;
   temp_state_t      w_state_nxt;
   logic [c_cw-1:0]  r_cnt;
   logic [c_cw-1:0]  w_cnt_nxt;
   logic             r_t_d;
   logic             r_tok;
   logic             w_tok_nxt;

   // State, counter, TOK and T edge-detect registers
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_t_d   <= 1'b0;
         r_tok   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_t_d   <= T;
         r_tok   <= w_tok_nxt;
      end
   end

   // Next-state, count and TOK decode; retrigger requires a fresh rise of T
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tok_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (T && !r_t_d) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = c_load;
            end
         end
         RUN: begin
            if (!T) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_tok_nxt   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (!T) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign TOK = r_tok;

endmodule : mezcla_temporizador

`default_nettype wire

// File: rtl/mezcladora_planta.sv
// ----------------------------------------------------------------------------
// Module  : mezcladora_planta
// Brief   : Behavioural plant for the mixer controller: tank level with clamp
//           and sticky overflow, level sensors, start pulse, process timer,
//           batch and mixing-cycle counters.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mezcladora_planta
   import mezcla_pkg::*;
#(
   parameter int W        = c_w_def,
   parameter int LVL_MAX  = c_lvl_max_def,
   parameter int FILL1    = c_fill1_def,
   parameter int FILL2    = c_fill2_def,
   parameter int DRAIN    = c_drain_def,
   parameter int DRAIN_B  = c_drain_b_def,
   parameter int HIGH_TH  = c_high_th_def,
   parameter int LOW_TH   = c_low_th_def,
   parameter int T_CYCLES = c_t_cycles_def
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic         V1,
   input  logic         V2,
   input  logic         V3,
   input  logic         M,
   input  logic         T,
   input  logic         S,
   input  logic         B,
   output logic         IN,
   output logic         TOK,
   output logic         P1,
   output logic         P2,
   output logic [W-1:0] Level,
   output logic         Overflow,
   output logic [7:0]   Batches,
   output logic [15:0]  MixCycles
);

   // Level arithmetic runs two bits wider and signed so under/overflow are visible
   localparam logic signed [W+1:0] c_fill1   = (W+2)'(FILL1);
   localparam logic signed [W+1:0] c_fill2   = (W+2)'(FILL2);
   localparam logic signed [W+1:0] c_drain   = (W+2)'(DRAIN);
   localparam logic signed [W+1:0] c_drain_b = (W+2)'(DRAIN_B);
   localparam logic signed [W+1:0] c_lvl_max = (W+2)'(LVL_MAX);
   localparam logic [W-1:0]        c_lvl_top = W'(LVL_MAX);
   localparam logic [W-1:0]        c_high_th = W'(HIGH_TH);
   localparam logic [W-1:0]        c_low_th  = W'(LOW_TH);

   logic [W-1:0]        r_level;
   logic                r_overflow;
   logic signed [W+1:0] w_nxt;
   logic                r_start_d;
   logic                r_in;
   logic                r_s_d;
   logic [7:0]          r_batches;
   logic [15:0]         r_mix;

   // Unclamped next level: all valves and the pump act together
   always_comb begin
      w_nxt = $signed({2'b00, r_level});
      if (V1) w_nxt = w_nxt + c_fill1;
      if (V2) w_nxt = w_nxt + c_fill2;
      if (V3) w_nxt = w_nxt - c_drain;
      if (B)  w_nxt = w_nxt - c_drain_b;
   end

   // Level register with clamp at empty and at capacity; spill sets sticky flag
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else if (w_nxt[W+1]) begin
         r_level <= '0;
      end else if (w_nxt > c_lvl_max) begin
         r_level    <= c_lvl_top;
         r_overflow <= 1'b1;
      end else begin
         r_level <= w_nxt[W-1:0];
      end
   end

   // Operator start: one registered pulse per rising edge of Start
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_start_d <= 1'b0;
         r_in      <= 1'b0;
      end else begin
         r_start_d <= Start;
         r_in      <= Start & ~r_start_d;
      end
   end

   // Batch counter on rising edges of S, wraps naturally at 8 bits
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_s_d     <= 1'b0;
         r_batches <= '0;
      end else begin
         r_s_d <= S;
         if (S && !r_s_d) begin
            r_batches <= r_batches + 8'd1;
         end
      end
   end

   // Mixer-on cycle counter, saturating at full scale
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_mix <= '0;
      end else if (M && (r_mix != 16'hFFFF)) begin
         r_mix <= r_mix + 16'd1;
      end
   end

   mezcla_temporizador #(
      .T_CYCLES (T_CYCLES)
   ) u_temporizador (
      .Clk   (Clk),
      .Reset (Reset),
      .T     (T),
      .TOK   (TOK)
   );

   assign Level     = r_level;
   assign Overflow  = r_overflow;
   assign P1        = (r_level >= c_high_th);
   assign P2        = (r_level >  c_low_th);
   assign IN        = r_in;
   assign Batches   = r_batches;
   assign MixCycles = r_mix;

endmodule : mezcladora_planta

`default_nettype wire
